// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH = 8;
    localparam int FIFO_DEFAULT_DEPTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port DEPTH x WIDTH array with synchronous write and registered read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset; the array keeps whatever it held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with wrap-bit pointers, occupancy count,
// almost flags, read-valid strobe and sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_DEFAULT_WIDTH,
    parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_LEVEL must not exceed DEPTH");
    end

    localparam logic [AW:0] ONE = 1;

    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] count_w;
    logic        wr_acc, rd_acc;

    // Status depends on registered pointers only, never on wr_en/rd_en.
    assign count        = wr_ptr - rd_ptr;
    assign count_w      = 32'(count);
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = count_w >= 32'(AF_LEVEL);
    assign almost_empty = count_w <= 32'(AE_LEVEL);
    assign wr_acc       = wr_en & ~full;
    assign rd_acc       = rd_en & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            rd_valid  <= rd_acc;
            overflow  <= overflow | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scripted and random stimulus against a queue-based FIFO model.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    logic [7:0] m_rd;
    logic       m_v, m_ovf, m_udf;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_all(input string where);
        int n;
        n = q.size();
        chk({where, " rd_valid"}, 32'(rd_valid), 32'(m_v));
        chk({where, " rd_data"}, 32'(rd_data), 32'(m_rd));
        chk({where, " count"}, 32'(count), 32'(n));
        chk({where, " full"}, 32'(full), 32'(n == 16));
        chk({where, " empty"}, 32'(empty), 32'(n == 0));
        chk({where, " almost_full"}, 32'(almost_full), 32'(n >= 14));
        chk({where, " almost_empty"}, 32'(almost_empty), 32'(n <= 2));
        chk({where, " overflow"}, 32'(overflow), 32'(m_ovf));
        chk({where, " underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_rd = '0;
        m_v = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input string where, input logic we, input logic [7:0] wd, input logic re);
        bit was_full, was_empty;
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        @(posedge clk);
        #1;
        was_full = q.size() == 16;
        was_empty = q.size() == 0;
        m_v = re && !was_empty;
        if (m_v) m_rd = q.pop_front();
        if (we && !was_full) q.push_back(wd);
        if (we && was_full) m_ovf = 1'b1;
        if (re && was_empty) m_udf = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(where);
    endtask

    task automatic do_reset(input string where);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(where);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 16; i++) step("refill", 1'b1, 8'(i), 1'b0);
        step("full_wr_rd", 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) step("drain_after_ovf", 1'b0, 8'h00, 1'b1);
        do_reset("reset2");
        step("empty_wr_rd", 1'b1, 8'h55, 1'b1);
        step("read_55", 1'b0, 8'h00, 1'b1);
        step("wr_33", 1'b1, 8'h33, 1'b0);
        step("rd_33", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) step("prime", 1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) step("wrap", 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 6; i++) step("burst", 1'b1, 8'(8'h90 + i), 1'b0);
        wr_en = 1'b1;
        wr_data = 8'hEE;
        rd_en = 1'b1;
        #2;
        do_reset("mid_reset");
        step("post_wr", 1'b1, 8'h77, 1'b0);
        step("post_rd", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 200) % 3;
            step("random",
                 $urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)),
                 8'($urandom),
                 $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            if (i % 997 == 500) do_reset("random_reset");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: next generation of the team's 4-bit/16-entry synchronous FIFO. Width, depth and almost-flag thresholds are configurable. All DEPTH entries are usable (extra pointer wrap bit), and read data holds its value between reads instead of being cleared. It adds an occupancy count, a read-valid strobe and sticky overflow/underflow error flags. It sits between producer and consumer blocks in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- AW (localparam), log2(DEPTH), address width

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion synchronous to clk by the system
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  read data, registered
- rd_valid  out  1  one-cycle pulse: rd_data was updated this cycle
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Pointers wr_ptr and rd_ptr are AW+1 bits. The low AW bits address memory, and the MSB is the wrap bit.
- empty: the pointers are equal. full: the low bits are equal and the MSBs differ.
- count = wr_ptr − rd_ptr, modulo 2^(AW+1). It may be held as a separate register updated +1/−1/0, provided the result is identical.
- Accepted write (wr_acc) = wr_en & !full. It writes mem[wr_ptr[AW-1:0]] and increments wr_ptr.
- Accepted read (rd_acc) = rd_en & !empty. It loads rd_data with mem[rd_ptr[AW-1:0]], increments rd_ptr and pulses rd_valid.
- When no read is accepted, rd_data holds its previous value and rd_valid = 0.
- Full and empty are evaluated from state at the start of the cycle:
  - Simultaneous wr_en & rd_en when full: read accepted, write rejected, overflow set, count goes DEPTH → DEPTH−1.
  - Simultaneous wr_en & rd_en when empty: write accepted, read rejected, underflow set, count goes 0 → 1. There is no write-to-read bypass.
  - Simultaneous accepted read and write otherwise: count unchanged, both pointers advance.
- overflow and underflow are sticky until reset.
- Pointer wrap is natural modulo-2^(AW+1) rollover. No special case is needed.

## Timing
- Reset (rst = 0, asynchronous): wr_ptr = rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0.
  - Resulting flags: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - Memory contents are not reset.
- Reset mid-operation discards all contents immediately, with no completion of in-flight requests.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data and rd_valid valid after edge N. rd_valid drops after edge N+1 unless another read is accepted.
- A write at edge N is visible to count and flags after edge N. The entry is readable by a read request sampled at edge N+1 or later.
- All status outputs (full, empty, almost_*, count) are registered or derived combinationally from registered pointers only. No path from wr_en or rd_en to any status output.
- Throughput: one write and one read per cycle sustained.

## Structure
- Shared package/include fifo_pkg:
  - clog2 helper function.
  - Default parameter constants (FIFO_DEFAULT_WIDTH = 8, FIFO_DEFAULT_DEPTH = 16).
- Sub-module fifo_ram:
  - Simple dual-port array of DEPTH × WIDTH.
  - Synchronous write port (we, waddr, wdata) and synchronous read port (re, raddr, rdata register).
  - No reset on the array.
- Top level holds pointers, count, flags and the error registers.
- Elaboration check: DEPTH not a power of two, or AF_LEVEL > DEPTH, is a fatal error.

## Test plan
(WIDTH = 8, DEPTH = 16, AF_LEVEL = 14, AE_LEVEL = 2)
- Reset, then write 0x01..0x10 on 16 consecutive cycles → count = 16, full = 1, almost_full asserted after the 14th write, overflow = 0. Then read 16 times → rd_data = 0x01..0x10 in order with rd_valid high on each, ending with empty = 1.
- From full, wr_en & rd_en with wr_data = 0xAA → rd_data = 0x01, count = 15, overflow = 1, 0xAA never read back.
- From empty, wr_en & rd_en with wr_data = 0x55 → rd_valid = 0, underflow = 1, count = 1. The next rd_en returns 0x55.
- Wrap-around: 40 cycles of simultaneous write/read of an incrementing pattern at count = 3 → count stays 3, output sequence is exact, pointers wrap past 31 without a flag glitch.
- Hold behaviour: after reading 0x33, idle 5 cycles → rd_data stays 0x33 and rd_valid = 0.
- Assert rst = 0 mid-burst at count = 9 → all outputs at reset values on the same cycle. After release, the first write/read pair returns the new data, not stale data.
